rs_encoder_lfsr: RTL and testbench

Parametrised systematic Reed-Solomon encoder over GF(2^8) that generalises the single fixed-coefficient parity stage into a complete NPAR-stage LFSR with its own codeword sequencing. It accepts K message symbols over a valid/ready stream, passes them through unchanged, then emits NPAR parity symbols from the LFSR with full backpressure support. It sits between the framer and the channel interleaver on the transmit path.

---
 rtl/rs_encoder_lfsr_pkg.sv | 49 ++++
 rtl/rs_encoder_lfsr_if.sv | 25 ++
 rtl/rs_encoder_lfsr_gf256_const_mul.sv | 14 +
 rtl/rs_encoder_lfsr.sv | 104 ++++++++++
 tb/tb_rs_encoder_lfsr.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rs_encoder_lfsr_pkg.sv
// Shared GF(2^8) arithmetic, state type and generator-polynomial helper for the
// Reed-Solomon LFSR encoder.
package rs_pkg;

  localparam logic [8:0]  GF_POLY  = 9'h11D;
  localparam int unsigned NPAR_MAX = 32;

  typedef enum logic {DATA = 1'b0, PARITY = 1'b1} rs_state_t;

  // g[0..NPAR-1], low-order coefficient first; the monic x^NPAR term is implied.
  typedef logic [NPAR_MAX-1:0][7:0] rs_coeffs_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ({sh[6:0], 1'b0} ^ GF_POLY[7:0]) : {sh[6:0], 1'b0};
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_pow(input int unsigned e);
    logic [7:0] acc;
    acc = 8'h01;
    for (int unsigned i = 0; i < (e % 255); i++) acc = gf_mul(acc, 8'h02);
    return acc;
  endfunction

  // Expands prod (x + alpha^(fcr+i)) one root at a time, highest term first.
  function automatic rs_coeffs_t gen_coeffs(input int unsigned npar, input int unsigned fcr);
    logic [NPAR_MAX:0][7:0] g;
    logic [7:0]             root;
    rs_coeffs_t             res;
    g    = '0;
    g[0] = 8'h01;
    for (int unsigned i = 0; i < npar; i++) begin
      root = gf_pow(fcr + i);
      for (int unsigned j = i + 1; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
    end
    res = '0;
    for (int unsigned j = 0; j < npar; j++) res[j] = g[j];
    return res;
  endfunction

endpackage

// File: rtl/rs_encoder_lfsr_if.sv
// Stream bundle for the RS encoder: message symbols in, codeword symbols out.
interface rs_encoder_lfsr_if;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_eop;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;
  logic       out_parity;

  modport master (
    output in_valid, in_data, in_eop, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_parity
  );

  modport slave (
    input  in_valid, in_data, in_eop, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_parity
  );

endinterface

// File: rtl/rs_encoder_lfsr_gf256_const_mul.sv
// Multiply an 8-bit GF(2^8) symbol by the elaboration-time constant C.
module gf256_const_mul
  import rs_pkg::*;
#(
  parameter logic [7:0] C = 8'h01
) (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Constant C folds the shift-and-add product into a fixed XOR network.
  always_comb dout = gf_mul(din, C);

endmodule

// File: rtl/rs_encoder_lfsr.sv
// Systematic RS(K+NPAR, K) encoder over GF(2^8): passes K message symbols
// through, then drains NPAR parity symbols from the LFSR, with backpressure.
// Optional build macro RS_SHORTENED_EN: in_eop ends a message early.
module rs_encoder_lfsr
  import rs_pkg::*;
#(
  parameter int unsigned K    = 239,
  parameter int unsigned NPAR = 16,
  parameter int unsigned FCR  = 0
) (
  input logic             clk,
  input logic             rst,
  rs_encoder_lfsr_if.slave bus
);

  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned PW = $clog2(NPAR);
  localparam rs_coeffs_t  G  = gen_coeffs(NPAR, FCR);

  rs_state_t     state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pcnt;
  logic [7:0]    r   [NPAR];
  logic [7:0]    gfb [NPAR];
  logic [7:0]    fb;
  logic          slot_free;
  logic          last_msg;

  assign slot_free    = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = (state == DATA) & slot_free;
  assign fb           = bus.in_data ^ r[NPAR-1];

  for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
    gf256_const_mul #(.C(G[gi])) u_mul (
      .din  (fb),
      .dout (gfb[gi])
    );
  end

`ifdef RS_SHORTENED_EN
  // Message ends on the K-th symbol or on an early in_eop.
  always_comb last_msg = (cnt == CW'(K - 1)) | bus.in_eop;
`else
  logic unused_eop;
  assign unused_eop = bus.in_eop;

  // Message always ends on the K-th symbol.
  always_comb last_msg = (cnt == CW'(K - 1));
`endif

  // Codeword sequencer: message pass-through with LFSR update, then parity drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= DATA;
      cnt            <= '0;
      pcnt           <= '0;
      for (int unsigned i = 0; i < NPAR; i++) r[i] <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_sop    <= 1'b0;
      bus.out_eop    <= 1'b0;
      bus.out_parity <= 1'b0;
    end else if (slot_free) begin
      unique case (state)
        DATA: begin
          if (bus.in_valid) begin
            r[0] <= gfb[0];
            for (int unsigned i = 1; i < NPAR; i++) r[i] <= r[i-1] ^ gfb[i];
            bus.out_valid  <= 1'b1;
            bus.out_data   <= bus.in_data;
            bus.out_sop    <= (cnt == '0);
            bus.out_eop    <= 1'b0;
            bus.out_parity <= 1'b0;
            if (last_msg) begin
              state <= PARITY;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            bus.out_valid <= 1'b0;
          end
        end
        PARITY: begin
          r[0] <= '0;
          for (int unsigned i = 1; i < NPAR; i++) r[i] <= r[i-1];
          bus.out_valid  <= 1'b1;
          bus.out_data   <= r[NPAR-1];
          bus.out_sop    <= 1'b0;
          bus.out_parity <= 1'b1;
          bus.out_eop    <= (pcnt == PW'(NPAR - 1));
          if (pcnt == PW'(NPAR - 1)) begin
            state <= DATA;
            pcnt  <= '0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= DATA;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_encoder_lfsr.sv
// Scoreboard bench for rs_encoder_lfsr: a default-parameter instance under
// random traffic and backpressure, plus a K=4/NPAR=2 instance for small vectors.
`timescale 1ns/1ps
module tb_rs_encoder_lfsr;

  localparam int unsigned K    = 239;
  localparam int unsigned NPAR = 16;
  localparam int unsigned FCR  = 0;
  localparam int unsigned SK   = 4;
  localparam int unsigned SNP  = 2;

  typedef logic [7:0]  sym_q_t [$];
  typedef logic [10:0] exp_t;   // {data, sop, eop, parity}

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;
  bit          bp_mode = 1'b0;

  exp_t        sb_q [$];
  exp_t        sq   [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs_encoder_lfsr_if bus ();
  rs_encoder_lfsr_if sbus ();

  rs_encoder_lfsr #(.K(K), .NPAR(NPAR), .FCR(FCR)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rs_encoder_lfsr #(.K(SK), .NPAR(SNP), .FCR(0)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  // ---------------- reference GF arithmetic via log/antilog tables -------------
  logic [7:0]  alog  [256];
  int unsigned glog  [256];
  logic [7:0]  gpoly [NPAR+1];   // gpoly[j] is the coefficient of x^j, gpoly[NPAR] = 1

  function automatic logic [7:0] m(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alog[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    logic [8:0] v;
    logic [7:0] root;
    v = 9'h001;
    for (int i = 0; i < 255; i++) begin
      alog[i]       = v[7:0];
      glog[v[7:0]]  = i;
      v = v << 1;
      if (v[8]) v = v ^ 9'h11D;
    end
    alog[255] = alog[0];
    glog[0]   = 0;
    gpoly[0]  = 8'h01;
    for (int j = 1; j <= NPAR; j++) gpoly[j] = 8'h00;
    for (int i = 0; i < NPAR; i++) begin
      root = alog[(FCR + i) % 255];
      for (int j = i + 1; j >= 1; j--) gpoly[j] = gpoly[j-1] ^ m(gpoly[j], root);
      gpoly[0] = m(gpoly[0], root);
    end
  endtask

  // Remainder of msg(x) * x^NPAR divided by g(x), by polynomial long division.
  function automatic sym_q_t ref_parity(input sym_q_t msg);
    sym_q_t     d;
    sym_q_t     par;
    logic [7:0] c;
    d = msg;
    for (int j = 0; j < NPAR; j++) d.push_back(8'h00);
    for (int i = 0; i < msg.size(); i++) begin
      c = d[i];
      for (int j = 1; j <= NPAR; j++) d[i+j] = d[i+j] ^ m(c, gpoly[NPAR-j]);
    end
    for (int j = 0; j < NPAR; j++) par.push_back(d[msg.size() + j]);
    return par;
  endfunction

  function automatic bit syndromes_zero(input sym_q_t cw);
    logic [7:0] x;
    logic [7:0] s;
    for (int j = 0; j < NPAR; j++) begin
      x = alog[(FCR + j) % 255];
      s = 8'h00;
      for (int k = 0; k < cw.size(); k++) s = m(s, x) ^ cw[k];
      if (s != 8'h00) return 1'b0;
    end
    return 1'b1;
  endfunction

  // ---------------- common helpers ---------------------------------------------
  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // ---------------- output backpressure ----------------------------------------
  always @(posedge clk) begin
    #1;
    bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor: main instance -------------------------------------
  sym_q_t      coll;
  logic        prev_stall = 1'b0;
  exp_t        prev_out   = '0;
  int unsigned eop_last   = 0;
  int unsigned eop_prev   = 0;

  always @(negedge clk) begin : mon_main
    exp_t act;
    exp_t want;
    if (!rst) begin
      coll.delete();
      prev_stall = 1'b0;
    end else begin
      act = {bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity};
      if (prev_stall) begin
        tests++;
        if (act !== prev_out || bus.out_valid !== 1'b1) begin
          fails++;
          $display("FAIL stall_hold: got %h valid %b, expected %h valid 1", act, bus.out_valid, prev_out);
        end
      end
      prev_stall = bus.out_valid & !bus.out_ready;
      prev_out   = act;
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_out: got %h, expected no output", act);
        end else begin
          want = sb_q.pop_front();
          if (act !== want) begin
            fails++;
            $display("FAIL out_symbol: got %h, expected %h", act, want);
          end
        end
        if (bus.out_sop) coll.delete();
        coll.push_back(bus.out_data);
        if (bus.out_eop) begin
          tests++;
          if (coll.size() != K + NPAR || !syndromes_zero(coll)) begin
            fails++;
            $display("FAIL syndrome: got len %0d nonzero-or-bad, expected len %0d all-zero",
                     coll.size(), K + NPAR);
          end
          eop_prev = eop_last;
          eop_last = cyc;
          coll.delete();
        end
      end
    end
  end

  // ---------------- monitor: small instance ------------------------------------
  always @(negedge clk) begin : mon_small
    exp_t act;
    exp_t want;
    if (rst && sbus.out_valid && sbus.out_ready) begin
      act = {sbus.out_data, sbus.out_sop, sbus.out_eop, sbus.out_parity};
      tests++;
      if (sq.size() == 0) begin
        fails++;
        $display("FAIL small_unexpected: got %h, expected no output", act);
      end else begin
        want = sq.pop_front();
        if (act !== want) begin
          fails++;
          $display("FAIL small_symbol: got %h, expected %h", act, want);
        end
      end
    end
  end

  // ---------------- drivers -----------------------------------------------------
  task automatic send_sym(input logic [7:0] d, input logic eop);
    int unsigned guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_eop   = eop;
    @(negedge clk);
    while (!bus.in_ready) begin
      guard++;
      if (guard > 2000) begin
        tests++;
        fails++;
        $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", guard);
        finish_run();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_small(input logic [7:0] d, input logic eop);
    int unsigned guard;
    guard = 0;
    sbus.in_valid = 1'b1;
    sbus.in_data  = d;
    sbus.in_eop   = eop;
    @(negedge clk);
    while (!sbus.in_ready) begin
      guard++;
      if (guard > 100) begin
        tests++;
        fails++;
        $display("FAIL small_in_ready_timeout: got in_ready 0 for %0d cycles, expected 1", guard);
        finish_run();
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
  endtask

  task automatic send_codeword(input sym_q_t msg, input int unsigned n, input bit gaps);
    sym_q_t par;
    logic   eop_bit;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
`ifdef RS_SHORTENED_EN
      eop_bit = (i == K - 1);
`else
      eop_bit = 1'($urandom_range(0, 1));
`endif
      sb_q.push_back({msg[i], (i == 0), 1'b0, 1'b0});
      send_sym(msg[i], eop_bit);
    end
    if (n == K) begin
      par = ref_parity(msg);
      for (int j = 0; j < NPAR; j++) sb_q.push_back({par[j], 1'b0, (j == NPAR - 1), 1'b1});
    end
  endtask

  function automatic sym_q_t rand_msg();
    sym_q_t q;
    for (int i = 0; i < K; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  task automatic wait_drain();
    int unsigned guard;
    guard = 0;
    while (sb_q.size() != 0 || sq.size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d+%0d pending, expected 0", sb_q.size(), sq.size());
        finish_run();
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence -----------------------------------------------
  initial begin
    sym_q_t msg;
    build_tables();
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_eop    = 1'b0;
    bus.out_ready = 1'b1;
    sbus.in_valid  = 1'b0;
    sbus.in_data   = 8'h00;
    sbus.in_eop    = 1'b0;
    sbus.out_ready = 1'b1;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity}, 64'h0);
    check("reset_in_ready", bus.in_ready, 1);
    check("small_reset_outputs", {sbus.out_valid, sbus.out_data, sbus.out_sop, sbus.out_eop, sbus.out_parity}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Small code: message 00 00 00 01 -> 00 00 00 01 03 02.
    sq.push_back({8'h00, 1'b1, 1'b0, 1'b0});
    sq.push_back({8'h00, 1'b0, 1'b0, 1'b0});
    sq.push_back({8'h00, 1'b0, 1'b0, 1'b0});
    sq.push_back({8'h01, 1'b0, 1'b0, 1'b0});
    sq.push_back({8'h03, 1'b0, 1'b0, 1'b1});
    sq.push_back({8'h02, 1'b0, 1'b1, 1'b1});
    send_small(8'h00, 1'b0);
    send_small(8'h00, 1'b0);
    send_small(8'h00, 1'b0);
    send_small(8'h01, 1'b0);
`ifdef RS_SHORTENED_EN
    // Shortened to one symbol: 01 -> 01 03 02.
    sq.push_back({8'h01, 1'b1, 1'b0, 1'b0});
    sq.push_back({8'h03, 1'b0, 1'b0, 1'b1});
    sq.push_back({8'h02, 1'b0, 1'b1, 1'b1});
    send_small(8'h01, 1'b1);
`endif
    wait_drain();

    // Two all-zero codewords back to back, no backpressure.
    msg.delete();
    for (int i = 0; i < K; i++) msg.push_back(8'h00);
    send_codeword(msg, K, 1'b0);
    send_codeword(msg, K, 1'b0);
    wait_drain();
    check("eop_spacing", eop_last - eop_prev, K + NPAR);

    // Random messages, full rate.
    for (int n = 0; n < 30; n++) send_codeword(rand_msg(), K, 1'b0);
    wait_drain();

    // Random messages with random source gaps and 50% out_ready.
    bp_mode = 1'b1;
    for (int n = 0; n < 30; n++) send_codeword(rand_msg(), K, 1'b1);
    wait_drain();
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after 100 message symbols, then a fresh codeword.
    msg = rand_msg();
    send_codeword(msg, 100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_outputs_seen", sb_q.size(), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_outputs", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_parity}, 64'h0);
    check("midreset_in_ready", bus.in_ready, 1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_midreset", bus.in_ready, 1);
    @(posedge clk);
    #1;
    send_codeword(msg, K, 1'b0);
    send_codeword(rand_msg(), K, 1'b0);
    wait_drain();

    finish_run();
  end

endmodule
